// File: rtl/vc_input_buffer.sv
// vc_input_buffer: four per-VC input FIFOs feeding a wormhole round-robin
// arbiter with a valid/ready output port and per-flit credit return.
// Optional build macro VCBUF_ERR_EN enables the sticky O_ERR flag
// (overflow, orphan discard, sequence error); without it O_ERR is tied 0.

module vc_input_buffer #(
  parameter int PTR_W = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [34:0] I_DATA,
  input  logic        I_VALID,
  input  logic [1:0]  I_VCH,
  output logic [34:0] O_DATA,
  output logic        O_VALID,
  output logic [1:0]  O_VCH,
  input  logic        I_READY,
  output logic [3:0]  O_CREDIT,
  output logic        O_ERR
);

  localparam int DEPTH = 1 << PTR_W;
  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  logic [34:0]      mem [4][DEPTH];
  logic [PTR_W-1:0] rd_ptr [4];
  logic [PTR_W-1:0] wr_ptr [4];
  logic [PTR_W:0]   count [4];
  logic [34:0]      head [4];
  logic [3:0]       nonempty;
  logic [3:0]       cand;
  logic [3:0]       orphan;

  arb_state_t state, state_nxt;
  logic [1:0] lock_vc, lock_vc_nxt;
  logic [1:0] last, last_nxt;
  logic       hold, hold_nxt;
  logic [1:0] hold_vc, hold_vc_nxt;

  logic [1:0] grant_vc;
  logic [1:0] rr_idx;
  logic       rr_found;
  logic       out_valid;
  logic       transfer;
  logic       orphan_pop;
  logic [1:0] orphan_vc;
  logic [3:0] pop;
  logic [3:0] wr_en;
  logic [34:0] data_q;
  logic [1:0]  vch_q;

  // Head flit of each VC and its classification as packet start or orphan
  always_comb begin
    for (int v = 0; v < 4; v++) begin
      head[v]     = mem[v][rd_ptr[v]];
      nonempty[v] = (count[v] != '0);
      cand[v]     = nonempty[v] & head[v][33];
      orphan[v]   = nonempty[v] & ~head[v][33];
    end
  end

  // Arbiter: grant selection, orphan discard and next-state logic
  always_comb begin
    state_nxt   = state;
    lock_vc_nxt = lock_vc;
    last_nxt    = last;
    hold_nxt    = hold;
    hold_vc_nxt = hold_vc;
    grant_vc    = lock_vc;
    out_valid   = 1'b0;
    rr_idx      = 2'd0;
    rr_found    = 1'b0;
    orphan_pop  = 1'b0;
    orphan_vc   = 2'd0;
    transfer    = 1'b0;

    if (state == LOCKED) begin
      grant_vc  = lock_vc;
      out_valid = nonempty[lock_vc];
    end else if (hold) begin
      grant_vc  = hold_vc;
      out_valid = 1'b1;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        rr_idx = last + 2'(i);
        if (!rr_found && cand[rr_idx]) begin
          rr_found = 1'b1;
          grant_vc = rr_idx;
        end
      end
      out_valid = rr_found;
    end

    if (state == IDLE) begin
      for (int i = 3; i >= 0; i--) begin
        if (orphan[i]) begin
          orphan_pop = 1'b1;
          orphan_vc  = 2'(i);
        end
      end
    end

    transfer = out_valid & I_READY;

    if (state == IDLE) begin
      if (transfer) begin
        hold_nxt = 1'b0;
        if (head[grant_vc][34:33] == 2'b01) begin
          state_nxt   = LOCKED;
          lock_vc_nxt = grant_vc;
        end else begin
          last_nxt = grant_vc;
        end
      end else if (out_valid) begin
        hold_nxt    = 1'b1;
        hold_vc_nxt = grant_vc;
      end
    end else if (transfer && head[lock_vc][34:33] == 2'b10) begin
      state_nxt = IDLE;
      last_nxt  = lock_vc;
    end
  end

  // Pop vector: forwarded flit plus at most one discarded orphan
  always_comb begin
    pop = '0;
    if (transfer) pop[grant_vc] = 1'b1;
    if (orphan_pop) pop[orphan_vc] = 1'b1;
  end

  // Write enable: a flit aimed at a full VC is dropped
  always_comb begin
    wr_en = '0;
    if (I_VALID && count[I_VCH] != FULL) wr_en[I_VCH] = 1'b1;
  end

  // FIFO pointers and occupancy counts
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int v = 0; v < 4; v++) begin
        rd_ptr[v] <= '0;
        wr_ptr[v] <= '0;
        count[v]  <= '0;
      end
    end else begin
      for (int v = 0; v < 4; v++) begin
        if (wr_en[v]) wr_ptr[v] <= wr_ptr[v] + PTR_W'(1);
        if (pop[v]) rd_ptr[v] <= rd_ptr[v] + PTR_W'(1);
        if (wr_en[v] && !pop[v]) count[v] <= count[v] + (PTR_W+1)'(1);
        else if (!wr_en[v] && pop[v]) count[v] <= count[v] - (PTR_W+1)'(1);
      end
    end
  end

  // Flit storage; contents need no reset since counts gate visibility
  always_ff @(posedge CLK) begin
    if (|wr_en) mem[I_VCH][wr_ptr[I_VCH]] <= I_DATA;
  end

  // Arbiter state, lock, round-robin pointer and held grant
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      lock_vc <= 2'd0;
      last    <= 2'd3;
      hold    <= 1'b0;
      hold_vc <= 2'd0;
    end else begin
      state   <= state_nxt;
      lock_vc <= lock_vc_nxt;
      last    <= last_nxt;
      hold    <= hold_nxt;
      hold_vc <= hold_vc_nxt;
    end
  end

  // Credit pulses one cycle after each pop, and last-shown output for idle cycles
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      O_CREDIT <= '0;
      data_q   <= '0;
      vch_q    <= '0;
    end else begin
      O_CREDIT <= pop;
      if (out_valid) begin
        data_q <= head[grant_vc];
        vch_q  <= grant_vc;
      end
    end
  end

  assign O_VALID = out_valid;
  assign O_DATA  = out_valid ? head[grant_vc] : data_q;
  assign O_VCH   = out_valid ? grant_vc : vch_q;

`ifdef VCBUF_ERR_EN
  logic err_q;
  logic overflow;
  logic seq_err;

  assign overflow = I_VALID & (count[I_VCH] == FULL);
  assign seq_err  = (state == LOCKED) & transfer & head[lock_vc][33];

  // Sticky error flag cleared only by reset
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) err_q <= 1'b0;
    else if (overflow || orphan_pop || seq_err) err_q <= 1'b1;
  end

  assign O_ERR = err_q;
`else
  assign O_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_vc_input_buffer.sv
// Testbench for vc_input_buffer: directed scenarios plus a randomized run
// checked against a queue-based reference model of the buffer and arbiter.

module tb_vc_input_buffer;

  localparam int PTR_W = 2;
  localparam int DEPTH = 1 << PTR_W;
`ifdef VCBUF_ERR_EN
  localparam bit ERR_EXP = 1'b1;
`else
  localparam bit ERR_EXP = 1'b0;
`endif

  logic        CLK;
  logic        RST;
  logic [34:0] I_DATA;
  logic        I_VALID;
  logic [1:0]  I_VCH;
  logic [34:0] O_DATA;
  logic        O_VALID;
  logic [1:0]  O_VCH;
  logic        I_READY;
  logic [3:0]  O_CREDIT;
  logic        O_ERR;

  int checks = 0;
  int errors = 0;

  logic [1:0]  obs_vch[$];
  logic [34:0] obs_data[$];
  int          cred_cnt[4];
  bit          saw_valid;

  // reference model state
  logic [34:0] mq[4][$];
  bit          m_locked;
  logic [1:0]  m_lock;
  logic [1:0]  m_last;
  bit          m_held;
  logic [1:0]  m_hvc;
  logic [3:0]  m_credit;
  bit          m_err;

  vc_input_buffer #(.PTR_W(PTR_W)) dut (
    .CLK(CLK), .RST(RST), .I_DATA(I_DATA), .I_VALID(I_VALID), .I_VCH(I_VCH),
    .O_DATA(O_DATA), .O_VALID(O_VALID), .O_VCH(O_VCH), .I_READY(I_READY),
    .O_CREDIT(O_CREDIT), .O_ERR(O_ERR)
  );

  // Free-running clock
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  // Watchdog so the run always terminates
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  task automatic clear_obs();
    obs_vch.delete();
    obs_data.delete();
    for (int k = 0; k < 4; k++) cred_cnt[k] = 0;
    saw_valid = 1'b0;
  endtask

  task automatic run_cycle(input bit iv, input logic [1:0] ivch, input logic [34:0] idata, input bit rdy);
    @(posedge CLK);
    #1;
    I_VALID = iv;
    I_VCH   = ivch;
    I_DATA  = idata;
    I_READY = rdy;
    if (O_VALID) saw_valid = 1'b1;
    if (O_VALID && I_READY) begin
      obs_vch.push_back(O_VCH);
      obs_data.push_back(O_DATA);
    end
    for (int k = 0; k < 4; k++) cred_cnt[k] += int'(O_CREDIT[k]);
  endtask

  task automatic do_reset();
    I_VALID = 1'b0;
    I_VCH   = 2'd0;
    I_DATA  = '0;
    I_READY = 1'b0;
    RST     = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    clear_obs();
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mq[k].delete();
    m_locked = 1'b0;
    m_lock   = 2'd0;
    m_last   = 2'd3;
    m_held   = 1'b0;
    m_hvc    = 2'd0;
    m_credit = 4'd0;
    m_err    = 1'b0;
  endtask

  task automatic model_outputs(output bit val, output logic [1:0] g);
    logic [1:0] c;
    val = 1'b0;
    g   = 2'd0;
    if (m_locked) begin
      g   = m_lock;
      val = (mq[m_lock].size() != 0);
    end else if (m_held) begin
      g   = m_hvc;
      val = 1'b1;
    end else begin
      for (int i = 1; i <= 4; i++) begin
        c = m_last + 2'(i);
        if (!val && mq[c].size() != 0 && mq[c][0][33]) begin
          val = 1'b1;
          g   = c;
        end
      end
    end
  endtask

  task automatic model_step(input bit iv, input logic [1:0] ivch, input logic [34:0] idata, input bit rdy);
    bit          val;
    logic [1:0]  g;
    logic [34:0] f;
    bit          orph;
    logic [1:0]  ov;
    bit          ovf;
    bit          ev;
    logic [3:0]  pops;
    model_outputs(val, g);
    pops = 4'd0;
    ev   = 1'b0;
    orph = 1'b0;
    ov   = 2'd0;
    if (!m_locked) begin
      for (int k = 0; k < 4; k++) begin
        if (!orph && mq[k].size() != 0 && !mq[k][0][33]) begin
          orph = 1'b1;
          ov   = 2'(k);
        end
      end
    end
    ovf = iv && (mq[ivch].size() == DEPTH);
    if (val && rdy) begin
      f = mq[g].pop_front();
      pops[g] = 1'b1;
      if (!m_locked) begin
        m_held = 1'b0;
        if (f[34:33] == 2'b01) begin
          m_locked = 1'b1;
          m_lock   = g;
        end else begin
          m_last = g;
        end
      end else if (f[34:33] == 2'b10) begin
        m_locked = 1'b0;
        m_last   = m_lock;
      end else if (f[33]) begin
        ev = 1'b1;
      end
    end else if (val && !m_locked) begin
      m_held = 1'b1;
      m_hvc  = g;
    end
    if (orph) begin
      void'(mq[ov].pop_front());
      pops[ov] = 1'b1;
      ev = 1'b1;
    end
    if (ovf) ev = 1'b1;
    else if (iv) mq[ivch].push_back(idata);
    m_credit = pops;
    if (ev && ERR_EXP) m_err = 1'b1;
  endtask

  task automatic test_reset();
    I_VALID = 1'b0;
    I_VCH   = 2'd0;
    I_DATA  = '0;
    I_READY = 1'b0;
    RST     = 1'b1;
    #1;
    checks += 5;
    if (O_VALID !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", O_VALID); end
    if (O_DATA !== 35'd0) begin errors++; $display("[TB] FAIL reset_data: got %h expected 0", O_DATA); end
    if (O_VCH !== 2'd0) begin errors++; $display("[TB] FAIL reset_vch: got %0d expected 0", O_VCH); end
    if (O_CREDIT !== 4'd0) begin errors++; $display("[TB] FAIL reset_credit: got %b expected 0000", O_CREDIT); end
    if (O_ERR !== 1'b0) begin errors++; $display("[TB] FAIL reset_err: got %b expected 0", O_ERR); end
    do_reset();
  endtask

  task automatic test_single();
    logic [34:0] flit;
    flit = {2'b11, 33'h1_2345_6789};
    do_reset();
    run_cycle(1'b1, 2'd2, flit, 1'b1);
    run_cycle(1'b0, 2'd0, '0, 1'b1);
    checks += 3;
    if (O_VALID !== 1'b1) begin errors++; $display("[TB] FAIL single_valid: got %b expected 1", O_VALID); end
    if (O_VCH !== 2'd2) begin errors++; $display("[TB] FAIL single_vch: got %0d expected 2", O_VCH); end
    if (O_DATA !== flit) begin errors++; $display("[TB] FAIL single_data: got %h expected %h", O_DATA, flit); end
    run_cycle(1'b0, 2'd0, '0, 1'b1);
    checks += 2;
    if (O_CREDIT !== 4'b0100) begin errors++; $display("[TB] FAIL single_credit: got %b expected 0100", O_CREDIT); end
    if (O_VALID !== 1'b0) begin errors++; $display("[TB] FAIL single_after_valid: got %b expected 0", O_VALID); end
    run_cycle(1'b0, 2'd0, '0, 1'b1);
    checks += 2;
    if (O_CREDIT !== 4'b0000) begin errors++; $display("[TB] FAIL single_credit_once: got %b expected 0000", O_CREDIT); end
    if (O_ERR !== 1'b0) begin errors++; $display("[TB] FAIL single_err: got %b expected 0", O_ERR); end
  endtask

  task automatic test_wormhole();
    logic [1:0]  tvc [6];
    logic [1:0]  tty [6];
    logic [34:0] exp_d [6];
    int          ord [6];
    tvc = '{2'd0, 2'd1, 2'd0, 2'd1, 2'd0, 2'd1};
    tty = '{2'b01, 2'b01, 2'b00, 2'b00, 2'b10, 2'b10};
    ord = '{0, 2, 4, 1, 3, 5};
    do_reset();
    for (int i = 0; i < 6; i++) begin
      exp_d[i] = {tty[i], 33'(32'h100 + i)};
      run_cycle(1'b1, tvc[i], exp_d[i], 1'b1);
    end
    repeat (14) run_cycle(1'b0, 2'd0, '0, 1'b1);
    checks++;
    if (obs_vch.size() != 6) begin
      errors++;
      $display("[TB] FAIL wormhole_count: got %0d flits expected 6", obs_vch.size());
    end else begin
      for (int i = 0; i < 6; i++) begin
        checks += 2;
        if (obs_vch[i] !== tvc[ord[i]]) begin errors++; $display("[TB] FAIL wormhole_vch[%0d]: got %0d expected %0d", i, obs_vch[i], tvc[ord[i]]); end
        if (obs_data[i] !== exp_d[ord[i]]) begin errors++; $display("[TB] FAIL wormhole_data[%0d]: got %h expected %h", i, obs_data[i], exp_d[ord[i]]); end
      end
    end
    checks += 2;
    if (cred_cnt[0] != 3) begin errors++; $display("[TB] FAIL wormhole_credit0: got %0d expected 3", cred_cnt[0]); end
    if (cred_cnt[1] != 3) begin errors++; $display("[TB] FAIL wormhole_credit1: got %0d expected 3", cred_cnt[1]); end
  endtask

  task automatic test_round_robin();
    logic [1:0] seq [3];
    seq = '{2'd0, 2'd1, 2'd3};
    do_reset();
    for (int i = 0; i < 9; i++) run_cycle(1'b1, seq[i % 3], {2'b11, 33'(i)}, 1'b0);
    repeat (14) run_cycle(1'b0, 2'd0, '0, 1'b1);
    checks++;
    if (obs_vch.size() != 9) begin
      errors++;
      $display("[TB] FAIL rr_count: got %0d flits expected 9", obs_vch.size());
    end else begin
      for (int i = 0; i < 9; i++) begin
        checks++;
        if (obs_vch[i] !== seq[i % 3]) begin errors++; $display("[TB] FAIL rr_order[%0d]: got %0d expected %0d", i, obs_vch[i], seq[i % 3]); end
      end
    end
  endtask

  task automatic test_overflow();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      run_cycle(1'b1, 2'd1, {2'b11, 33'(i + 50)}, 1'b0);
      if (i == 4) begin
        checks++;
        if (O_ERR !== 1'b0) begin errors++; $display("[TB] FAIL ovf_err_early: got %b expected 0", O_ERR); end
      end
    end
    run_cycle(1'b0, 2'd0, '0, 1'b0);
    checks++;
    if (O_ERR !== ERR_EXP) begin errors++; $display("[TB] FAIL ovf_err: got %b expected %b", O_ERR, ERR_EXP); end
    repeat (10) run_cycle(1'b0, 2'd0, '0, 1'b1);
    checks += 4;
    if (obs_vch.size() != DEPTH) begin errors++; $display("[TB] FAIL ovf_flits: got %0d expected %0d", obs_vch.size(), DEPTH); end
    else if (obs_data[DEPTH-1] !== {2'b11, 33'(DEPTH - 1 + 50)}) begin errors++; $display("[TB] FAIL ovf_last_data: got %h", obs_data[DEPTH-1]); end
    if (cred_cnt[1] != DEPTH) begin errors++; $display("[TB] FAIL ovf_credits: got %0d expected %0d", cred_cnt[1], DEPTH); end
    if (O_ERR !== ERR_EXP) begin errors++; $display("[TB] FAIL ovf_err_sticky: got %b expected %b", O_ERR, ERR_EXP); end
    if (O_VALID !== 1'b0) begin errors++; $display("[TB] FAIL ovf_drained: got %b expected 0", O_VALID); end
  endtask

  task automatic test_orphan();
    do_reset();
    run_cycle(1'b1, 2'd3, {2'b00, 33'h0_dead_beef}, 1'b1);
    repeat (5) run_cycle(1'b0, 2'd0, '0, 1'b1);
    checks += 4;
    if (saw_valid !== 1'b0) begin errors++; $display("[TB] FAIL orphan_valid: got %b expected 0", saw_valid); end
    if (cred_cnt[3] != 1) begin errors++; $display("[TB] FAIL orphan_credit3: got %0d expected 1", cred_cnt[3]); end
    if (cred_cnt[0] + cred_cnt[1] + cred_cnt[2] != 0) begin errors++; $display("[TB] FAIL orphan_other_credit: got %0d expected 0", cred_cnt[0] + cred_cnt[1] + cred_cnt[2]); end
    if (O_ERR !== ERR_EXP) begin errors++; $display("[TB] FAIL orphan_err: got %b expected %b", O_ERR, ERR_EXP); end
  endtask

  task automatic test_reset_mid_packet();
    logic [34:0] b1;
    logic [34:0] s;
    b1 = {2'b00, 33'h111};
    s  = {2'b11, 33'h1_5555_aaaa};
    do_reset();
    run_cycle(1'b1, 2'd0, {2'b01, 33'h100}, 1'b0);
    run_cycle(1'b1, 2'd0, b1, 1'b1);
    run_cycle(1'b1, 2'd0, {2'b00, 33'h222}, 1'b0);
    run_cycle(1'b0, 2'd0, '0, 1'b0);
    checks += 2;
    if (O_VALID !== 1'b1 || O_VCH !== 2'd0) begin errors++; $display("[TB] FAIL mid_locked: got valid %b vch %0d expected 1/0", O_VALID, O_VCH); end
    if (O_DATA !== b1) begin errors++; $display("[TB] FAIL mid_body: got %h expected %h", O_DATA, b1); end
    #2;
    RST = 1'b1;
    #1;
    checks += 5;
    if (O_VALID !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_valid: got %b expected 0", O_VALID); end
    if (O_DATA !== 35'd0) begin errors++; $display("[TB] FAIL mid_rst_data: got %h expected 0", O_DATA); end
    if (O_VCH !== 2'd0) begin errors++; $display("[TB] FAIL mid_rst_vch: got %0d expected 0", O_VCH); end
    if (O_CREDIT !== 4'd0) begin errors++; $display("[TB] FAIL mid_rst_credit: got %b expected 0000", O_CREDIT); end
    if (O_ERR !== 1'b0) begin errors++; $display("[TB] FAIL mid_rst_err: got %b expected 0", O_ERR); end
    #1;
    RST = 1'b0;
    clear_obs();
    run_cycle(1'b1, 2'd2, s, 1'b1);
    repeat (6) run_cycle(1'b0, 2'd0, '0, 1'b1);
    checks += 3;
    if (obs_vch.size() != 1) begin errors++; $display("[TB] FAIL mid_after_count: got %0d expected 1", obs_vch.size()); end
    else if (obs_vch[0] !== 2'd2 || obs_data[0] !== s) begin errors++; $display("[TB] FAIL mid_after_flit: got vch %0d data %h expected 2 %h", obs_vch[0], obs_data[0], s); end
    if (cred_cnt[2] != 1) begin errors++; $display("[TB] FAIL mid_after_credit2: got %0d expected 1", cred_cnt[2]); end
    if (cred_cnt[0] != 0) begin errors++; $display("[TB] FAIL mid_after_credit0: got %0d expected 0", cred_cnt[0]); end
  endtask

  task automatic test_random();
    bit          gen_pkt [4];
    bit          ev;
    logic [1:0]  eg;
    bit          iv;
    logic [1:0]  ivch;
    logic [1:0]  ty;
    logic [34:0] idata;
    bit          rdy;
    do_reset();
    model_reset();
    for (int k = 0; k < 4; k++) gen_pkt[k] = 1'b0;
    for (int cyc = 0; cyc < 3000; cyc++) begin
      @(posedge CLK);
      #1;
      model_outputs(ev, eg);
      checks += 3;
      if (O_VALID !== ev) begin errors++; $display("[TB] FAIL rand_valid @%0d: got %b expected %b", cyc, O_VALID, ev); end
      if (O_CREDIT !== m_credit) begin errors++; $display("[TB] FAIL rand_credit @%0d: got %b expected %b", cyc, O_CREDIT, m_credit); end
      if (O_ERR !== m_err) begin errors++; $display("[TB] FAIL rand_err @%0d: got %b expected %b", cyc, O_ERR, m_err); end
      if (ev) begin
        checks += 2;
        if (O_VCH !== eg) begin errors++; $display("[TB] FAIL rand_vch @%0d: got %0d expected %0d", cyc, O_VCH, eg); end
        if (O_DATA !== mq[eg][0]) begin errors++; $display("[TB] FAIL rand_data @%0d: got %h expected %h", cyc, O_DATA, mq[eg][0]); end
      end
      iv   = ($urandom_range(0, 99) < 55);
      ivch = 2'($urandom_range(0, 3));
      if (!gen_pkt[ivch]) ty = ($urandom_range(0, 2) == 0) ? 2'b11 : 2'b01;
      else ty = ($urandom_range(0, 2) == 0) ? 2'b10 : 2'b00;
      if ($urandom_range(0, 19) == 0) ty = 2'($urandom_range(0, 3));
      if (iv) gen_pkt[ivch] = (ty == 2'b01) ? 1'b1 : ((ty == 2'b00) ? gen_pkt[ivch] : 1'b0);
      idata = {ty, 1'($urandom_range(0, 1)), 32'($urandom)};
      rdy   = ($urandom_range(0, 9) < 7);
      I_VALID = iv;
      I_VCH   = ivch;
      I_DATA  = idata;
      I_READY = rdy;
      model_step(iv, ivch, idata, rdy);
    end
  endtask

  // Scenario sequence and summary
  initial begin
    RST = 1'b1;
    I_VALID = 1'b0;
    I_VCH = 2'd0;
    I_DATA = '0;
    I_READY = 1'b0;
    model_reset();
    clear_obs();
    test_reset();
    test_single();
    test_wormhole();
    test_round_robin();
    test_overflow();
    test_orphan();
    test_reset_mid_packet();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/vc_input_buffer.md
# vc_input_buffer

Per-virtual-channel input buffer that consumes the 35-bit flit stream produced by the packet generator (data, valid, VC number) and presents it to the router crossbar. Each of the four VCs has its own FIFO. Credits are returned upstream one per popped flit. A wormhole round-robin arbiter forwards whole packets, never interleaving flits of different packets, over a valid/ready output port.

## Interface
Parameters:
- PTR_W, 2, FIFO address width; per-VC depth DEPTH = 2**PTR_W (legal PTR_W ≥ 1).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  asynchronous, active-high reset.
- I_DATA  in  35  input flit.
- I_VALID  in  1  flit present this cycle; no ready, upstream is credit-controlled.
- I_VCH  in  2  target VC of I_DATA.
- O_DATA  out  35  flit at head of granted VC FIFO.
- O_VALID  out  1  O_DATA valid.
- O_VCH  out  2  VC of O_DATA.
- I_READY  in  1  downstream accepts; transfer = O_VALID & I_READY.
- O_CREDIT  out  4  bit v pulses one cycle per flit popped from VC v.
- O_ERR  out  1  sticky error flag.

Clocking and reset (decided): one clock, CLK; reset RST is asynchronous and active-high.

## Operation
- Flit type field I_DATA[34:33]:
  - 2'b01 head
  - 2'b00 body
  - 2'b10 tail
  - 2'b11 single (head+tail)
  - Payload [32:0] is passed through untouched.
- Write path:
  - I_VALID=1 writes I_DATA into FIFO[I_VCH] at the edge and increments count[I_VCH].
  - If count[I_VCH]==DEPTH at the start of the cycle, the flit is dropped. This is an overflow, even if the same VC pops that cycle.
- FIFOs:
  - Circular, PTR_W-bit read/write pointers that wrap naturally.
  - Count is PTR_W+1 bits, range 0..DEPTH.
- Arbiter FSM, states IDLE and LOCKED, with a 2-bit lock_vc and a 2-bit last pointer:
  - **IDLE**:
    - Candidates are nonempty VCs whose head flit is type 01 or 11.
    - Grant goes to the first candidate in round-robin order starting at last+1 (mod 4).
    - O_VALID=1 iff any candidate exists.
    - On transfer of a 01 flit: go to LOCKED, lock_vc=granted VC.
    - On transfer of an 11 flit: stay IDLE, last=granted VC.
  - **LOCKED**:
    - Only lock_vc is eligible; O_VALID = (count[lock_vc]≠0).
    - Transfer of a 10 flit: go to IDLE, last=lock_vc.
    - Transfer of a 00 flit: stay LOCKED.
    - A 01 or 11 flit seen while LOCKED is a sequence error. It is still forwarded, and the FSM stays LOCKED.
  - **Orphan flits**: in IDLE, any nonempty VC whose head flit is 00 or 10 is popped and discarded, at most one such VC per cycle (lowest index). This does not block a same-cycle grant on another VC. It counts as a sequence error.
- Each pop (transfer or discard) registers O_CREDIT[v]=1 for the next cycle. Simultaneous pops on different VCs pulse their credit bits together.
- O_DATA/O_VCH show the head of the granted VC when O_VALID=1. Their value is don't-care (hold last) when O_VALID=0.
- Simultaneous write and pop on one non-full VC: both occur and the count is unchanged.

## Timing
- Reset values:
  - all counts and pointers 0
  - state IDLE
  - last=3 (VC0 first priority)
  - lock_vc=0
  - O_CREDIT=0
  - O_ERR=0
  - O_VALID=0
  - O_DATA=0
  - O_VCH=0
- Latency:
  - A flit written at edge t can appear on O_VALID in the cycle after edge t. There is no same-cycle bypass.
  - O_VALID/O_DATA/O_VCH are combinational from FIFO state and the FSM; there is no path from I_READY to O_VALID.
- O_CREDIT is registered, asserted the cycle after the pop edge, for exactly one cycle per pop.
- O_VALID may drop only on reset. Once asserted in LOCKED, the flit holds until transferred. In IDLE, an arbitration result held without I_READY is not re-arbitrated until transfer.
- Reset mid-packet: all buffered flits are lost, the FSM returns to IDLE, and no credits are emitted for the lost flits.

## Configuration
- Macro VCBUF_ERR_EN.
- Defined: O_ERR sets on overflow, orphan discard, or sequence error, and stays 1 until RST.
- Undefined: O_ERR is tied 0 and the error-detect logic is removed. Overflow drop, orphan discard and forwarding behaviour are unchanged.

## Test plan
- Reset, then a single 11 flit with payload 33'h1_2345_6789 on VC2 with I_READY=1 → O_VALID the next cycle, O_VCH=2, data exact, O_CREDIT=4'b0100 one cycle later.
- Packets head/body/tail on VC0 and VC1 written interleaved, I_READY=1 → output shows all of VC0 (3 flits) then all of VC1; no interleave; credits total 3 per VC.
- Three 11 flits each on VC0, VC1, VC3, held until all buffered, I_READY=1 → output VC order 0,1,3,0,1,3,0,1,3.
- PTR_W=2, five flits to VC1 with I_READY=0 → count stops at 4, 5th dropped, O_ERR=1 (0 with macro undefined); after draining, exactly 4 credits.
- Body flit alone on VC3 in IDLE → discarded, no O_VALID, O_CREDIT[3] pulses, O_ERR=1.
- RST asserted while VC0 is LOCKED with 2 flits pending → all outputs at reset values immediately; a new 11 flit afterwards forwards normally.
